factorial_controller: RTL and testbench

FACTORIAL_CONTROLLER -- requirements
Module: factorial_controller

---
 rtl/factorial_controller.sv | 153 +++++++++++++++
 tb/tb_factorial_controller.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/factorial_controller.sv
// Sequences an external 64x64 multiplier to compute n! with a start/clear FSM.
// Operands are driven only while a multiply is in flight; result is registered.
module factorial_controller #(
    parameter int unsigned NMAX = 20
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic           clear,
    input  logic [5:0]     n,
    output logic [63:0]    result,
    output logic           done,
    output logic           busy,
    output logic           error,
    output logic [2:0]     state,
    output logic           mul_op_start,
    output logic           mul_op_clear,
    output logic [63:0]    mul_multiplicand,
    output logic [63:0]    mul_multiplier,
    input  logic [127:0]   mul_result,
    input  logic [1:0]     mul_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_MSTART = 3'd2,
        S_MWAIT  = 3'd3,
        S_MCLEAR = 3'd4,
        S_DONE   = 3'd5,
        S_ERROR  = 3'd6
    } state_e;

    localparam logic [1:0] MUL_IDLE = 2'b00;
    localparam logic [1:0] MUL_DONE = 2'b10;
    localparam logic [6:0] NMAX_W   = 7'(NMAX);

    state_e      state_q, state_d;
    logic [63:0] acc_q, acc_d;
    logic [63:0] result_q, result_d;
    logic [5:0]  k_q, k_d;
    logic        mclr_sent_q, mclr_sent_d;
    logic        busy_w;

    assign busy_w = (state_q == S_LOAD) || (state_q == S_MSTART) ||
                    (state_q == S_MWAIT) || (state_q == S_MCLEAR);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            acc_q       <= 64'd1;
            k_q         <= '0;
            result_q    <= '0;
            mclr_sent_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            k_q         <= k_d;
            result_q    <= result_d;
            mclr_sent_q <= mclr_sent_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        acc_d            = acc_q;
        k_d              = k_q;
        result_d         = result_q;
        mclr_sent_d      = 1'b0;
        mul_op_start     = 1'b0;
        mul_op_clear     = 1'b0;
        mul_multiplicand = '0;
        mul_multiplier   = '0;

        case (state_q)
            S_IDLE: begin
                if (clear) begin
                    result_d = '0;
                end else if (start) begin
                    if ({1'b0, n} > NMAX_W) begin
                        state_d  = S_ERROR;
                        result_d = '0;
                    end else begin
                        // n is captured here and nowhere else
                        state_d = S_LOAD;
                        acc_d   = 64'd1;
                        k_d     = n;
                    end
                end
            end
            S_LOAD: begin
                if (k_q <= 6'd1) begin
                    state_d  = S_DONE;
                    result_d = acc_q;
                end else begin
                    state_d = S_MSTART;
                end
            end
            S_MSTART: begin
                mul_op_start     = 1'b1;
                mul_multiplicand = acc_q;
                mul_multiplier   = {58'd0, k_q};
                state_d          = S_MWAIT;
            end
            S_MWAIT: begin
                mul_op_start     = 1'b1;
                mul_multiplicand = acc_q;
                mul_multiplier   = {58'd0, k_q};
                if (mul_state == MUL_DONE) begin
                    acc_d   = mul_result[63:0];
                    k_d     = k_q - 6'd1;
                    state_d = S_MCLEAR;
                end
            end
            S_MCLEAR: begin
                // clear pulse on the first cycle, then wait for the multiplier to idle
                mul_op_clear = !mclr_sent_q;
                mclr_sent_d  = 1'b1;
                if (mclr_sent_q && (mul_state == MUL_IDLE)) begin
                    if (k_q <= 6'd1) begin
                        state_d  = S_DONE;
                        result_d = acc_q;
                    end else begin
                        state_d = S_MSTART;
                    end
                end
            end
            S_DONE, S_ERROR: begin
                if (clear) begin
                    state_d  = S_IDLE;
                    result_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // abort: drop the operation and flush the multiplier in the same cycle
        if (clear && busy_w) begin
            state_d      = S_IDLE;
            result_d     = '0;
            mclr_sent_d  = 1'b0;
            mul_op_start = 1'b0;
            mul_op_clear = 1'b1;
        end
    end

    assign state  = state_q;
    assign result = result_q;
    assign done   = (state_q == S_DONE);
    assign error  = (state_q == S_ERROR);
    assign busy   = busy_w;

endmodule

// File: tb/tb_factorial_controller.sv
// Bench for factorial_controller: behavioral multiplier with random latency,
// scoreboard of expected operand pairs and results per run.
module tb_factorial_controller;

    logic         clk, reset, start, clear;
    logic [5:0]   n_in;
    logic [63:0]  result, mul_multiplicand, mul_multiplier;
    logic         done, busy, error, mul_op_start, mul_op_clear;
    logic [2:0]   state;
    logic [127:0] mul_result;
    logic [1:0]   mul_state;

    int total = 0;
    int bad   = 0;

    factorial_controller #(.NMAX(20)) dut (
        .clk(clk), .reset(reset), .start(start), .clear(clear), .n(n_in),
        .result(result), .done(done), .busy(busy), .error(error), .state(state),
        .mul_op_start(mul_op_start), .mul_op_clear(mul_op_clear),
        .mul_multiplicand(mul_multiplicand), .mul_multiplier(mul_multiplier),
        .mul_result(mul_result), .mul_state(mul_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // multiplier model: IDLE -> EXEC (random latency) -> DONE, clear returns to IDLE
    logic [63:0]  pa, pb;
    int unsigned  lat;
    always @(posedge clk) begin
        if (reset) begin
            mul_state  <= 2'b00;
            mul_result <= '0;
        end else begin
            case (mul_state)
                2'b00: if (mul_op_start) begin
                    pa <= mul_multiplicand; pb <= mul_multiplier;
                    lat <= $urandom_range(3, 0); mul_state <= 2'b01;
                end
                2'b01: if (mul_op_clear) mul_state <= 2'b00;
                       else if (lat == 0) begin mul_result <= pa * pb; mul_state <= 2'b10; end
                       else lat <= lat - 1;
                2'b10: if (mul_op_clear) mul_state <= 2'b00;
                default: mul_state <= 2'b00;
            endcase
        end
    end

    // observation monitor
    logic [127:0] obs_q[$];
    logic [127:0] exp_q[$];
    logic [127:0] last_ops;
    int stray = 0, unstable = 0, clr_cnt = 0;
    always @(negedge clk) begin
        if (!reset) begin
            if (mul_op_clear) clr_cnt++;
            if (mul_op_start && !(state == 3'd2 || state == 3'd3)) stray++;
            if (state == 3'd2) begin
                last_ops = {mul_multiplicand, mul_multiplier};
                obs_q.push_back(last_ops);
            end
            if (state == 3'd3 && mul_op_start && ({mul_multiplicand, mul_multiplier} !== last_ops))
                unstable++;
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic pulse_clear();
        clear = 1'b1; tick(); clear = 1'b0;
    endtask

    // reference model: push the (acc, k) operand pairs and return n!
    function automatic logic [63:0] push_exp(input int nn);
        logic [63:0] acc = 64'd1;
        for (int k = nn; k >= 2; k--) begin
            exp_q.push_back({acc, 64'(k)});
            acc = acc * 64'(k);
        end
        return acc;
    endfunction

    task automatic run_fact(input int nn, output logic timed_out);
        obs_q.delete();
        start = 1'b1; n_in = 6'(nn);
        tick();
        timed_out = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (done || error) begin timed_out = 1'b0; break; end
            tick();
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; clear = 1'b0; n_in = '0;
        tick(); tick();
        total++; if (state !== 3'd0) begin bad++; $display("FAIL rst_state got=%0d want=0", state); end
        total++; if (result !== 64'd0) begin bad++; $display("FAIL rst_result got=%h want=0", result); end
        total++; if ({done, busy, error, mul_op_start, mul_op_clear} !== 5'b0) begin
            bad++; $display("FAIL rst_flags got=%b want=00000", {done, busy, error, mul_op_start, mul_op_clear});
        end
        total++; if ({mul_multiplicand, mul_multiplier} !== 128'd0) begin
            bad++; $display("FAIL rst_operands got=%h want=0", {mul_multiplicand, mul_multiplier});
        end
        reset = 1'b0; tick();
    endtask

    task automatic test_small();
        for (int nn = 0; nn < 2; nn++) begin
            obs_q.delete();
            start = 1'b1; n_in = 6'(nn);
            tick();
            total++; if (state !== 3'd1 || done !== 1'b0) begin
                bad++; $display("FAIL small_edge1 n=%0d got state=%0d done=%b want state=1 done=0", nn, state, done);
            end
            tick();
            total++; if (done !== 1'b1) begin bad++; $display("FAIL small_latency n=%0d got done=%b want=1", nn, done); end
            total++; if (result !== 64'd1) begin bad++; $display("FAIL small_result n=%0d got=%h want=1", nn, result); end
            total++; if (obs_q.size() !== 0) begin bad++; $display("FAIL small_noops n=%0d got=%0d want=0", nn, obs_q.size()); end
            start = 1'b0;
            pulse_clear();
        end
    endtask

    task automatic test_n5();
        logic to;
        logic [63:0] want;
        exp_q.delete();
        want = push_exp(5);
        run_fact(5, to);
        total++; if (to) begin bad++; $display("FAIL n5_timeout got=timeout want=done"); end
        total++; if (obs_q.size() !== 4) begin bad++; $display("FAIL n5_nmul got=%0d want=4", obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            logic [127:0] e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            total++; if (o !== e) begin bad++; $display("FAIL n5_ops got=%h want=%h", o, e); end
        end
        total++; if (done !== 1'b1 || result !== 64'h78 || want !== 64'h78) begin
            bad++; $display("FAIL n5_result got=%h done=%b want=78", result, done);
        end
        pulse_clear();
        total++; if (state !== 3'd0 || result !== 64'd0) begin
            bad++; $display("FAIL done_clear got state=%0d result=%h want 0/0", state, result);
        end
    endtask

    task automatic test_limits();
        logic to;
        exp_q.delete();
        void'(push_exp(20));
        run_fact(20, to);
        total++; if (to || result !== 64'h21C3677C82B40000 || error !== 1'b0) begin
            bad++; $display("FAIL n20_result got=%h err=%b to=%b want=21c3677c82b40000", result, error, to);
        end
        total++; if (obs_q.size() !== 19) begin bad++; $display("FAIL n20_nmul got=%0d want=19", obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            logic [127:0] e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            total++; if (o !== e) begin bad++; $display("FAIL n20_ops got=%h want=%h", o, e); end
        end
        pulse_clear();
        run_fact(21, to);
        total++; if (error !== 1'b1 || result !== 64'd0 || done !== 1'b0) begin
            bad++; $display("FAIL n21_error got err=%b done=%b res=%h want err=1 done=0 res=0", error, done, result);
        end
        total++; if (obs_q.size() !== 0) begin bad++; $display("FAIL n21_noops got=%0d want=0", obs_q.size()); end
        start = 1'b1; tick();
        total++; if (state !== 3'd6) begin bad++; $display("FAIL err_ignore_start got=%0d want=6", state); end
        start = 1'b0;
        pulse_clear();
        total++; if (state !== 3'd0) begin bad++; $display("FAIL err_clear got=%0d want=0", state); end
    endtask

    task automatic test_reset_mid();
        logic to;
        int c0;
        obs_q.delete();
        start = 1'b1; n_in = 6'd10;
        to = 1'b1;
        for (int i = 0; i < 200; i++) begin tick(); if (state == 3'd3) begin to = 1'b0; break; end end
        total++; if (to) begin bad++; $display("FAIL rmid_reach got=timeout want=mwait"); end
        c0 = clr_cnt;
        reset = 1'b1; tick();
        total++; if (state !== 3'd0 || result !== 64'd0 || {done, busy, error} !== 3'b0) begin
            bad++; $display("FAIL rmid_state got st=%0d res=%h dbe=%b want 0/0/000", state, result, {done, busy, error});
        end
        total++; if ({mul_op_start, mul_op_clear} !== 2'b0 || {mul_multiplicand, mul_multiplier} !== 128'd0) begin
            bad++; $display("FAIL rmid_mul got st=%b cl=%b ops=%h want 0", mul_op_start, mul_op_clear, {mul_multiplicand, mul_multiplier});
        end
        reset = 1'b0; start = 1'b0; tick();
        total++; if (clr_cnt !== c0) begin bad++; $display("FAIL rmid_noclear got=%0d want=%0d", clr_cnt, c0); end
        exp_q.delete();
        void'(push_exp(3));
        run_fact(3, to);
        total++; if (to || result !== 64'd6) begin bad++; $display("FAIL rmid_n3 got=%h want=6", result); end
        pulse_clear();
    endtask

    task automatic test_clear_abort();
        logic to;
        int c0;
        obs_q.delete();
        start = 1'b1; n_in = 6'd7;
        to = 1'b1;
        for (int i = 0; i < 200; i++) begin tick(); if (state == 3'd3) begin to = 1'b0; break; end end
        total++; if (to) begin bad++; $display("FAIL abort_reach got=timeout want=mwait"); end
        start = 1'b0;
        c0 = clr_cnt;
        clear = 1'b1; #1;
        total++; if (mul_op_clear !== 1'b1 || mul_op_start !== 1'b0) begin
            bad++; $display("FAIL abort_pulse got clr=%b st=%b want clr=1 st=0", mul_op_clear, mul_op_start);
        end
        tick(); clear = 1'b0;
        total++; if (state !== 3'd0 || result !== 64'd0 || busy !== 1'b0) begin
            bad++; $display("FAIL abort_idle got st=%0d res=%h busy=%b want 0/0/0", state, result, busy);
        end
        tick(); tick(); tick();
        total++; if (clr_cnt - c0 !== 1) begin bad++; $display("FAIL abort_onepulse got=%0d want=1", clr_cnt - c0); end
    endtask

    task automatic test_busy_noise();
        logic to;
        exp_q.delete(); obs_q.delete();
        void'(push_exp(6));
        start = 1'b1; n_in = 6'd6;
        tick();
        for (int i = 0; i < 40 && busy; i++) begin
            start = 1'($urandom_range(1, 0));
            n_in  = 6'($urandom_range(63, 0));
            tick();
        end
        to = 1'b1;
        for (int i = 0; i < 3000; i++) begin if (done) begin to = 1'b0; break; end tick(); end
        start = 1'b0;
        total++; if (to || result !== 64'h2D0) begin bad++; $display("FAIL noise_result got=%h want=2d0", result); end
        total++; if (obs_q.size() !== exp_q.size()) begin
            bad++; $display("FAIL noise_nmul got=%0d want=%0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            logic [127:0] e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            total++; if (o !== e) begin bad++; $display("FAIL noise_ops got=%h want=%h", o, e); end
        end
        pulse_clear();
    endtask

    task automatic test_back_to_back();
        logic to;
        logic [63:0] res_q[$];
        int ns[5] = '{2, 3, 12, 17, 9};
        foreach (ns[j]) begin
            exp_q.delete();
            res_q.push_back(push_exp(ns[j]));
            run_fact(ns[j], to);
            begin
                logic [63:0] w;
                w = res_q.pop_front();
                total++; if (to || result !== w) begin bad++; $display("FAIL b2b_result n=%0d got=%h want=%h", ns[j], result, w); end
            end
            total++; if (obs_q.size() !== exp_q.size()) begin
                bad++; $display("FAIL b2b_nmul n=%0d got=%0d want=%0d", ns[j], obs_q.size(), exp_q.size());
            end
            while (exp_q.size() > 0 && obs_q.size() > 0) begin
                logic [127:0] e, o;
                e = exp_q.pop_front(); o = obs_q.pop_front();
                total++; if (o !== e) begin bad++; $display("FAIL b2b_ops n=%0d got=%h want=%h", ns[j], o, e); end
            end
            pulse_clear();
        end
    endtask

    task automatic test_monitors();
        total++; if (stray !== 0) begin bad++; $display("FAIL op_start_outside got=%0d want=0", stray); end
        total++; if (unstable !== 0) begin bad++; $display("FAIL operands_unstable got=%0d want=0", unstable); end
    endtask

    initial begin
        test_reset();
        test_small();
        test_n5();
        test_limits();
        test_reset_mid();
        test_clear_abort();
        test_busy_noise();
        test_back_to_back();
        test_monitors();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
